// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron processing element: FSM state
// encoding, accumulator width rule and a generic signed saturator.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_FIN1 = 2'd1,
        ST_FIN2 = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Working width for intermediate arithmetic; wide enough for any legal
    // accumulator plus the shifted bias and rounding constant.
    localparam int SAT_W = 128;
    typedef logic signed [SAT_W-1:0] wide_t;

    // Accumulator width: full-precision lane sum plus guard headroom.
    function automatic int acc_width(input int data_w, input int lanes, input int guard_w);
        return 2 * data_w + $clog2(lanes) + guard_w;
    endfunction

    // Clamp v to the signed range of a w-bit number; clamped flags a clip.
    function automatic wide_t sat_signed(input wide_t v, input int w, output logic clamped);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        clamped = 1'b0;
        if (v > hi) begin
            sat_signed = hi;
            clamped    = 1'b1;
        end else if (v < lo) begin
            sat_signed = lo;
            clamped    = 1'b1;
        end else begin
            sat_signed = v;
        end
    endfunction

endpackage

// File: rtl/neuron_lane_mult.sv
// Combinational dot product of one beat: LANES signed multipliers feeding
// a full-precision adder reduction.
module neuron_lane_mult
    import neuron_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int SUM_W  = 2 * DATA_W + $clog2(LANES)
) (
    input  logic [LANES*DATA_W-1:0] x,
    input  logic [LANES*DATA_W-1:0] w,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [2*DATA_W-1:0] prod [LANES];

    // Per-lane signed products, operands sign-extended to product width.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic signed [DATA_W-1:0] a;
            logic signed [DATA_W-1:0] b;
            a = x[i*DATA_W +: DATA_W];
            b = w[i*DATA_W +: DATA_W];
            prod[i] = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        end
    end

    // Sum all lane products at full precision; no overflow is possible.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + SUM_W'(prod[i]);
        end
    end

endmodule

// File: rtl/neuron_pe.sv
// Neuron processing element: streams x/w beats into a saturating
// accumulator, then adds bias, rounds, saturates, optionally applies ReLU
// and holds the result until the consumer takes it.
module neuron_pe
    import neuron_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int LANES   = 4,
    parameter int GUARD_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_x,
    input  logic [LANES*DATA_W-1:0] in_w,
    input  logic                    in_last,
    input  logic [DATA_W-1:0]       bias,
    input  logic                    relu_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_y,
    output logic                    out_sat
);

    localparam int SUM_W = 2 * DATA_W + $clog2(LANES);
    localparam int ACC_W = acc_width(DATA_W, LANES, GUARD_W);

    state_t                    state;
    logic                      fire;
    logic signed [SUM_W-1:0]   lane_sum;
    logic signed [SUM_W-1:0]   lane_sum_p1;
    logic                      vld_p1;
    logic signed [ACC_W-1:0]   acc_p2;
    logic                      acc_sat_p2;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      acc_clamp;
    logic signed [DATA_W-1:0]  bias_q;
    logic                      relu_q;
    wide_t                     res_w;
    logic                      res_clamp;
    logic signed [DATA_W-1:0]  y_sat;
    logic signed [DATA_W-1:0]  y_fin;

    assign fire      = in_valid && in_ready;
    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_OUT);

    neuron_lane_mult #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .SUM_W  (SUM_W)
    ) u_mult (
        .x   (in_x),
        .w   (in_w),
        .sum (lane_sum)
    );

    // Control FSM: accumulate beats, two finishing cycles, then hold output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            case (state)
                ST_ACC:  if (fire && in_last) state <= ST_FIN1;
                ST_FIN1: state <= ST_FIN2;
                ST_FIN2: state <= ST_OUT;
                ST_OUT:  if (out_ready) state <= ST_ACC;
                default: state <= ST_ACC;
            endcase
        end
    end

    // Stage 1: register the lane sum of each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_sum_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= fire;
            if (fire) lane_sum_p1 <= lane_sum;
        end
    end

    // Bias and ReLU enable are taken from the last beat of the vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q <= '0;
            relu_q <= 1'b0;
        end else if (fire && in_last) begin
            bias_q <= bias;
            relu_q <= relu_en;
        end
    end

    // Saturating accumulate of the stage-1 sum.
    always_comb begin
        acc_clamp = 1'b0;
        acc_next  = ACC_W'(sat_signed(wide_t'(acc_p2) + wide_t'(lane_sum_p1), ACC_W, acc_clamp));
    end

    // Stage 2: accumulator update; cleared once the result is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p2     <= '0;
            acc_sat_p2 <= 1'b0;
        end else if (state == ST_OUT && out_ready) begin
            acc_p2     <= '0;
            acc_sat_p2 <= 1'b0;
        end else if (vld_p1) begin
            acc_p2     <= acc_next;
            acc_sat_p2 <= acc_sat_p2 | acc_clamp;
        end
    end

    // Bias add, round half up, arithmetic shift, clamp and optional ReLU.
    always_comb begin
        res_clamp = 1'b0;
        res_w = wide_t'(acc_p2) + (wide_t'(bias_q) <<< FRAC_W) + (wide_t'(1) <<< (FRAC_W - 1));
        res_w = res_w >>> FRAC_W;
        y_sat = DATA_W'(sat_signed(res_w, DATA_W, res_clamp));
        y_fin = (relu_q && y_sat < 0) ? '0 : y_sat;
    end

    // Stage 3: output register, loaded on the FIN2 -> OUT edge and held in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_y   <= '0;
            out_sat <= 1'b0;
        end else if (state == ST_FIN2) begin
            out_y   <= y_fin;
            out_sat <= res_clamp | acc_sat_p2;
        end
    end

endmodule
